// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-requester writeback arbiter (ALU vs load) with starvation guard
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [31:0] alu_data,
  input  logic [4:0]  alu_rd,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  input  logic [4:0]  mem_rd,
  output logic        mem_ready,
  input  logic        wb_stall,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_sel
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    G_ALU = 2'd1,
    G_MEM = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] starve_cnt;
  logic          alu_xfer;
  logic          mem_xfer;

  // Grant: loads win contention unless the ALU has been denied STARVE_LIMIT times in a row.
  // Readies look only at valids, the stall and the counter, never at data or rd.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (rst && !wb_stall) begin
      if (mem_valid && !(alu_valid && (starve_cnt == LIMIT))) begin
        mem_ready = 1'b1;
      end else if (alu_valid) begin
        alu_ready = 1'b1;
      end
    end
  end

  assign alu_xfer = alu_valid & alu_ready;
  assign mem_xfer = mem_valid & mem_ready;

  // FSM next state: remembers which requester (if any) transferred last cycle.
  always_comb begin
    next_state = IDLE;
    if (alu_xfer) begin
      next_state = G_ALU;
    end else if (mem_xfer) begin
      next_state = G_MEM;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Starvation counter: counts consecutive losses of a pending ALU result to a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!alu_valid) begin
      starve_cnt <= '0;
    end else if (wb_stall) begin
      starve_cnt <= starve_cnt;
    end else if (alu_xfer) begin
      starve_cnt <= '0;
    end else if (mem_ready && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Writeback register: captures the accepted result; x0 writes are accepted but not enabled.
  // With no transfer the address/data/select hold and only the enable drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      wb_sel  <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      if (alu_xfer) begin
        wb_en   <= |alu_rd;
        wb_rd   <= alu_rd;
        wb_data <= alu_data;
      end else if (mem_xfer) begin
        wb_en   <= |mem_rd;
        wb_rd   <= mem_rd;
        wb_data <= mem_data;
      end
      if (next_state != IDLE) begin
        wb_sel <= (next_state == G_MEM);
      end
    end
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the maximum consecutive cycles the ALU requester may be denied while valid.
REQ-002 The block SHALL have the following ports, one per line:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU result pending
- alu_data  input  32  ALU result
- alu_rd  input  5  ALU destination register
- alu_ready  output  1  ALU result accepted this cycle (combinational)
- mem_valid  input  1  load data pending
- mem_data  input  32  load data
- mem_rd  input  5  load destination register
- mem_ready  output  1  load data accepted this cycle (combinational)
- wb_stall  input  1  register-file write port unavailable
- wb_en  output  1  register-file write enable (registered)
- wb_rd  output  5  write address (registered)
- wb_data  output  32  write data, 32-bit mux output (registered)
- wb_sel  output  1  mux select of last accept: 0=ALU, 1=MEM (registered)

Function
REQ-003 A transfer SHALL occur on a requester exactly when its valid and ready are both high in the same cycle.
REQ-004 At most one of alu_ready, mem_ready SHALL be high in any cycle; both SHALL be low when wb_stall=1 or rst=0.
REQ-005 ready SHALL be asserted only to a requester whose valid is high; ready SHALL NOT depend on the requester's data or rd.
REQ-006 Grant rule: only one valid -> that one wins; both valid -> MEM wins unless starve_cnt == STARVE_LIMIT, in which case ALU wins.
REQ-007 Internal starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment when alu_valid=1, mem_ready=1, alu_ready=0, and saturate at STARVE_LIMIT.
REQ-008 starve_cnt SHALL clear to 0 on an ALU transfer or in any cycle with alu_valid=0; it SHALL hold when wb_stall=1.
REQ-009 Latency: data, rd and select of a transfer in cycle N SHALL appear on wb_data, wb_rd, wb_sel in cycle N+1.
REQ-010 wb_en SHALL be 1 in cycle N+1 only if a transfer occurred in cycle N and its rd != 0; rd == 0 transfers SHALL be accepted and discarded (wb_en=0).
REQ-011 With no transfer in cycle N, wb_en SHALL be 0 in N+1 and wb_rd, wb_data, wb_sel SHALL hold their previous values.
REQ-012 FSM states: IDLE (no transfer last cycle), G_ALU (last transfer ALU), G_MEM (last transfer MEM); next state = G_ALU/G_MEM on the respective transfer, else IDLE; wb_sel SHALL equal (state==G_MEM) except in IDLE, where it holds.
REQ-013 Back-to-back transfers SHALL be sustained at one per cycle with no bubble.
REQ-014 A requester SHALL keep valid, data and rd stable until accepted; the block does not check this.

Reset
REQ-015 While rst=0, asynchronously: wb_en=0, wb_rd=0, wb_data=0, wb_sel=0, starve_cnt=0, state=IDLE, both readies 0.
REQ-016 Reset asserted mid-operation SHALL drop any result accepted in the preceding cycle (no write after reset release).
REQ-017 The first transfer after reset release SHALL be possible in the first rising edge with rst=1.

Verification
REQ-018 Single ALU: alu_valid=1, alu_rd=5, alu_data=32'h43392179 one cycle -> alu_ready=1 same cycle; next cycle wb_en=1, wb_rd=5, wb_data=32'h43392179, wb_sel=0.
REQ-019 Contention: both valid, mem_rd=7, mem_data=32'hD41202AB, alu_rd=3 -> mem_ready=1, alu_ready=0; next cycle wb_data=32'hD41202AB, wb_sel=1.
REQ-020 Starvation: both valid continuously, STARVE_LIMIT=4 -> MEM accepted 4 cycles, ALU on 5th, then starve_cnt=0 and MEM wins again.
REQ-021 x0 discard: mem_valid=1, mem_rd=0, mem_data=32'hB540ED3A -> mem_ready=1; next cycle wb_en=0, wb_data=32'hB540ED3A.
REQ-022 Stall: wb_stall=1 with both valid for 3 cycles -> no ready, wb_en=0, starve_cnt unchanged; on release arbitration resumes per REQ-006.
REQ-023 Reset mid-transfer: transfer in cycle N, rst=0 asynchronously before edge N+1 -> wb_en=0, all outputs 0 immediately, no write after release.
